// File: rtl/bus_arbiter.sv
// Two-master shared-bus arbiter and sequencer for one synchronous single-port memory.
// Serves one master at a time: IDLE -> WAIT (LATENCY cycles) -> GRANT (one-cycle bgrt_ pulse).
module bus_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  breq0_,
  input  logic                  memread0,
  input  logic                  memwrite0,
  input  logic [ADDR_WIDTH-1:0] adr0,
  input  logic [DATA_WIDTH-1:0] writedata0,
  output logic                  bgrt0_,
  input  logic                  breq1_,
  input  logic                  memread1,
  input  logic                  memwrite1,
  input  logic [ADDR_WIDTH-1:0] adr1,
  input  logic [DATA_WIDTH-1:0] writedata1,
  output logic                  bgrt1_,
  output logic [DATA_WIDTH-1:0] memdata,
  output logic [ADDR_WIDTH-1:0] mem_adr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  localparam logic [3:0] LP_WAIT_INIT = 4'(LATENCY - 1);

  state_t r_state;
  state_t w_next;
  logic   r_owner;
  logic   r_last;
  logic   r_write;
  logic [3:0] r_waitcnt;

  logic                  w_req0;
  logic                  w_req1;
  logic                  w_sel;
  logic                  w_owner_req;
  logic [ADDR_WIDTH-1:0] w_adr;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign w_req0      = ~breq0_;
  assign w_req1      = ~breq1_;
  // On contention the master not served last wins; otherwise whoever is asking.
  assign w_sel       = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_owner_req = r_owner ? w_req1 : w_req0;
  assign w_adr       = r_owner ? adr1 : adr0;
  assign w_wdata     = r_owner ? writedata1 : writedata0;
  assign owner       = r_owner;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_write   <= 1'b0;
      r_waitcnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_owner   <= w_sel;
            r_write   <= w_sel ? memwrite1 : memwrite0;
            r_waitcnt <= LP_WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (r_waitcnt != 4'd0) begin
            r_waitcnt <= r_waitcnt - 4'd1;
          end
        end
        S_GRANT: begin
          r_last <= r_owner;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req0 | w_req1) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_owner_req) begin
          w_next = S_IDLE;
        end else if (r_waitcnt == 4'd0) begin
          w_next = S_GRANT;
        end
      end
      S_GRANT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bgrt0_    = 1'b1;
    bgrt1_    = 1'b1;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    memdata   = '0;
    busy      = 1'b0;
    case (r_state)
      S_WAIT: begin
        busy      = 1'b1;
        mem_adr   = w_adr;
        mem_wdata = w_wdata;
        mem_re    = ~r_write;
      end
      S_GRANT: begin
        busy      = 1'b1;
        mem_adr   = w_adr;
        mem_wdata = w_wdata;
        if (r_owner) begin
          bgrt1_ = 1'b0;
        end else begin
          bgrt0_ = 1'b0;
        end
        if (r_write) begin
          mem_we = 1'b1;
        end else begin
          memdata = mem_rdata;
        end
      end
      default: begin
      end
    endcase
  end

endmodule
